// File: rtl/timer_ctrl.sv
// timer_ctrl: shared prescaler driving CH down-counting timer channels.
// Optional TIMER_CTRL_CLKOUT_EN adds a per-channel toggling clk_out.
module timer_ctrl #(
  parameter int CH        = 4,
  parameter int PW        = 15,
  parameter int CW        = 16,
  parameter int PRESC_RST = 9999
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [2:0]    cfg_cmd,
  input  logic [2:0]    cfg_ch,
  input  logic [CW-1:0] cfg_data,
  output logic [CH-1:0] ch_tick,
  output logic [CH-1:0] pending,
  output logic [CH-1:0] running,
  output logic          irq
`ifdef TIMER_CTRL_CLKOUT_EN
  ,
  output logic [CH-1:0] clk_out
`endif
);

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_SPER  = 3'd1;
  localparam logic [2:0] OP_SONE  = 3'd2;
  localparam logic [2:0] OP_STOP  = 3'd3;
  localparam logic [2:0] OP_ACK   = 3'd4;
  localparam logic [2:0] OP_PRESC = 3'd5;
  localparam logic [2:0] OP_MASK  = 3'd6;

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [PW-1:0] P_ONE = PW'(1);

  state_e        state_q, state_d;
  logic          exec;
  logic [2:0]    cmd_q;
  logic [2:0]    ch_q;
  logic [CW-1:0] data_q;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CH-1:0] mask_q, mask_d;
  logic          irq_q, irq_d;
  logic          ptick, upd;
  logic          do_presc, do_mask, chan_op;

  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];
  logic [CW-1:0] rld_q [CH];
  logic [CW-1:0] rld_d [CH];
  logic [CH-1:0] per_q, per_d;
  logic [CH-1:0] run_q, run_d;
  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] tick_q, exp_c;
  logic [CH-1:0] sel;

  // Command FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Command FSM next state: one accept, one execute cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cfg_valid) state_d = S_EXEC;
      S_EXEC: state_d = S_IDLE;
    endcase
  end

  // Command FSM outputs
  always_comb begin
    cfg_ready = (state_q == S_IDLE);
    exec      = (state_q == S_EXEC);
  end

  // Decode of the latched command and prescaler next state
  always_comb begin
    do_presc = exec && (cmd_q == OP_PRESC);
    do_mask  = exec && (cmd_q == OP_MASK);
    chan_op  = exec && !cmd_q[2];
    ptick    = (pcnt_q == presc_q);
    upd      = ptick && !do_presc;
    pcnt_d   = ptick ? '0 : pcnt_q + P_ONE;
    presc_d  = presc_q;
    mask_d   = mask_q;
    if (do_presc) begin
      presc_d = data_q[PW-1:0];
      pcnt_d  = '0;
    end
    if (do_mask) mask_d = data_q[CH-1:0];
    irq_d = |(pend_q & mask_q);
  end

  // Per-channel next state; a channel command pre-empts that channel's tick
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      sel[i]   = exec && (ch_q == 3'(i));
      cnt_d[i] = cnt_q[i];
      rld_d[i] = rld_q[i];
      per_d[i] = per_q[i];
      run_d[i] = run_q[i];
      exp_c[i] = 1'b0;
      if (sel[i] && chan_op) begin
        unique case (cmd_q)
          OP_LOAD: begin
            rld_d[i] = data_q;
            cnt_d[i] = data_q;
          end
          OP_SPER: begin
            run_d[i] = 1'b1;
            per_d[i] = 1'b1;
          end
          OP_SONE: begin
            run_d[i] = 1'b1;
            per_d[i] = 1'b0;
          end
          OP_STOP: run_d[i] = 1'b0;
          default: ;
        endcase
      end else if (upd && run_q[i]) begin
        if (cnt_q[i] <= C_ONE) begin
          exp_c[i] = 1'b1;
          if (per_q[i]) begin
            cnt_d[i] = rld_q[i];
          end else begin
            cnt_d[i] = '0;
            run_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] - C_ONE;
        end
      end
      pend_d[i] = pend_q[i] | exp_c[i];
      if (sel[i] && (cmd_q == OP_ACK) && !exp_c[i]) pend_d[i] = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      pcnt_q  <= '0;
      presc_q <= PW'(PRESC_RST);
      mask_q  <= '0;
      irq_q   <= 1'b0;
      tick_q  <= '0;
      pend_q  <= '0;
      run_q   <= '0;
      per_q   <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
        rld_q[i] <= '0;
      end
    end else begin
      if (cfg_valid && cfg_ready) begin
        cmd_q  <= cfg_cmd;
        ch_q   <= cfg_ch;
        data_q <= cfg_data;
      end
      pcnt_q  <= pcnt_d;
      presc_q <= presc_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
      tick_q  <= exp_c;
      pend_q  <= pend_d;
      run_q   <= run_d;
      per_q   <= per_d;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        rld_q[i] <= rld_d[i];
      end
    end
  end

`ifdef TIMER_CTRL_CLKOUT_EN
  logic [CH-1:0] clko_q;

  // Square wave: toggle on every expiry, held while stopped
  always_ff @(posedge clk) begin
    if (rst) clko_q <= '0;
    else     clko_q <= clko_q ^ exp_c;
  end

  assign clk_out = clko_q;
`endif

  assign ch_tick = tick_q;
  assign pending = pend_q;
  assign running = run_q;
  assign irq     = irq_q;

endmodule
